// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: the in-order writeback stage has priority,
// and one auxiliary long-latency result is held in a single-entry buffer until
// a free port cycle. If the buffered result keeps losing to the pipeline, a
// one-cycle writeback stall forces it out. Port outputs are registered.
//
// state | meaning
// IDLE  | buffer empty, aux writer may hand over a result
// PEND  | buffer holds an aux result waiting for a free port cycle
// FORCE | writeback stalled for one cycle while the buffer retires
module wb_port_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we_wb,
  input  logic [ADDR_WIDTH-1:0] pipe_addr_wb,
  input  logic [DATA_WIDTH-1:0] pipe_data_wb,
  output logic                  stall_wb,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_data,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0] buf_addr, buf_addr_nxt;
  logic [DATA_WIDTH-1:0] buf_data, buf_data_nxt;
  logic                  port_we_nxt;
  logic [ADDR_WIDTH-1:0] port_addr_nxt;
  logic [DATA_WIDTH-1:0] port_data_nxt;
  logic                  pipe_req;
  logic                  aux_take;

  // Writes to r0 are architecturally void, so they never count as requests.
  assign pipe_req  = pipe_we_wb && (pipe_addr_wb != '0);
  assign aux_ready = (state == IDLE) && !rst;
  assign aux_take  = aux_valid && aux_ready && (aux_addr != '0);
  assign stall_wb  = (state == FORCE);

  // Next-state, buffer and port-winner selection.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    buf_addr_nxt  = buf_addr;
    buf_data_nxt  = buf_data;
    port_we_nxt   = 1'b0;
    port_addr_nxt = '0;
    port_data_nxt = '0;
    case (state)
      IDLE: begin
        if (pipe_req) begin
          port_we_nxt   = 1'b1;
          port_addr_nxt = pipe_addr_wb;
          port_data_nxt = pipe_data_wb;
        end
        // A freshly captured entry waits at least one cycle before retiring.
        if (aux_take) begin
          buf_addr_nxt = aux_addr;
          buf_data_nxt = aux_data;
          wait_cnt_nxt = '0;
          state_nxt    = PEND;
        end
      end
      PEND: begin
        if (!pipe_req) begin
          port_we_nxt   = 1'b1;
          port_addr_nxt = buf_addr;
          port_data_nxt = buf_data;
          wait_cnt_nxt  = '0;
          state_nxt     = IDLE;
        end else begin
          port_we_nxt   = 1'b1;
          port_addr_nxt = pipe_addr_wb;
          port_data_nxt = pipe_data_wb;
          if (pipe_addr_wb == buf_addr) begin
            // The pipe value is younger in program order; the buffer is stale.
            wait_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else if (wait_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
            wait_cnt_nxt = '0;
            state_nxt    = FORCE;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
      end
      FORCE: begin
        // Writeback is stalled and re-presents its request next cycle.
        port_we_nxt   = 1'b1;
        port_addr_nxt = buf_addr;
        port_data_nxt = buf_data;
        wait_cnt_nxt  = '0;
        state_nxt     = IDLE;
      end
      default: begin
        wait_cnt_nxt = '0;
        state_nxt    = IDLE;
      end
    endcase
  end

  // State, buffer and registered port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      buf_addr <= '0;
      buf_data <= '0;
      reg_we   <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      buf_addr <= buf_addr_nxt;
      buf_data <= buf_data_nxt;
      reg_we   <= port_we_nxt;
      reg_addr <= port_addr_nxt;
      reg_data <= port_data_nxt;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_wb_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst;
  logic          pipe_we_wb;
  logic [AW-1:0] pipe_addr_wb;
  logic [DW-1:0] pipe_data_wb;
  logic          stall_wb;
  logic          aux_valid;
  logic          aux_ready;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_data;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: is an aux result parked, what it is, how many cycles it has lost
  // to the pipeline, and whether the next cycle is the forced stall.
  bit          m_buf;
  logic [AW-1:0] m_baddr;
  logic [DW-1:0] m_bdata;
  int          m_blocked;
  bit          m_stall;
  bit          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  wb_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we_wb(pipe_we_wb), .pipe_addr_wb(pipe_addr_wb), .pipe_data_wb(pipe_data_wb),
    .stall_wb(stall_wb),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_buf = 1'b0; m_baddr = '0; m_bdata = '0;
    m_blocked = 0; m_stall = 1'b0;
    e_we = 1'b0; e_addr = '0; e_data = '0;
  endfunction

  // One clock edge of the arbiter's rules.
  function automatic void model_step(input bit pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                                     input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    bit preq;
    preq = pwe && (pa != 0);
    e_we = 1'b0; e_addr = '0; e_data = '0;
    if (m_stall) begin
      e_we = 1'b1; e_addr = m_baddr; e_data = m_bdata;
      m_buf = 1'b0; m_stall = 1'b0; m_blocked = 0;
    end else if (!m_buf) begin
      if (preq) begin e_we = 1'b1; e_addr = pa; e_data = pd; end
      if (av && aa != 0) begin
        m_buf = 1'b1; m_baddr = aa; m_bdata = ad; m_blocked = 0;
      end
    end else if (!preq) begin
      e_we = 1'b1; e_addr = m_baddr; e_data = m_bdata;
      m_buf = 1'b0; m_blocked = 0;
    end else begin
      e_we = 1'b1; e_addr = pa; e_data = pd;
      if (pa == m_baddr) begin
        m_buf = 1'b0; m_blocked = 0;
      end else begin
        m_blocked++;
        if (m_blocked == LIMIT) m_stall = 1'b1;
      end
    end
  endfunction

  // Entered and left at a falling edge.
  task automatic cycle(input bit pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    pipe_we_wb = pwe; pipe_addr_wb = pa; pipe_data_wb = pd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
    #1;
    chk("stall_wb", stall_wb, m_stall);
    chk("aux_ready", aux_ready, !m_buf);
    @(posedge clk);
    model_step(pwe, pa, pd, av, aa, ad);
    #1;
    chk("reg_we", reg_we, e_we);
    if (e_we) begin
      chk("reg_addr", reg_addr, e_addr);
      chk("reg_data", reg_data, e_data);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Entered at a falling edge; asserts reset immediately and releases it two cycles later.
  task automatic do_reset(input bit av);
    aux_valid = av; aux_addr = 5'd6; aux_data = 32'h66;
    pipe_we_wb = 1'b0; pipe_addr_wb = '0; pipe_data_wb = '0;
    rst = 1'b1;
    #1;
    chk("rst_reg_we", reg_we, 0);
    chk("rst_aux_ready", aux_ready, 0);
    chk("rst_stall_wb", stall_wb, 0);
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_hold_reg_we", reg_we, 0);
    rst = 1'b0;
    aux_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pipe_we_wb = 1'b0; pipe_addr_wb = '0; pipe_data_wb = '0;
    aux_valid = 1'b0; aux_addr = '0; aux_data = '0;
    model_clear();
    @(negedge clk);

    // Reset with aux_valid held high.
    do_reset(1'b1);
    #1;
    chk("release_aux_ready", aux_ready, 1);

    // Pipe write in IDLE, then a write to r0.
    cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0);
    chk("t2_we", reg_we, 1);
    chk("t2_addr", reg_addr, 3);
    chk("t2_data", reg_data, 32'hDEADBEEF);
    cycle(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
    chk("t2_r0_we", reg_we, 0);

    // Aux result retires on a free port cycle.
    cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h1234);
    chk("t3_ready_t1", aux_ready, 0);
    chk("t3_we_t1", reg_we, 0);
    idle();
    chk("t3_we_t2", reg_we, 1);
    chk("t3_addr", reg_addr, 7);
    chk("t3_data", reg_data, 32'h1234);
    chk("t3_ready_t2", aux_ready, 1);

    // Starvation: four pipe wins, one forced stall, then the held pipe write.
    cycle(1'b0, '0, '0, 1'b1, 5'd11, 32'hBB);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'd5, 32'h100 + i, 1'b0, '0, '0);
      chk("t4_pipe_addr", reg_addr, 5);
      chk("t4_stall", stall_wb, (i == 3));
    end
    cycle(1'b1, 5'd5, 32'h77, 1'b0, '0, '0);
    chk("t4_force_addr", reg_addr, 11);
    chk("t4_force_data", reg_data, 32'hBB);
    chk("t4_stall_once", stall_wb, 0);
    cycle(1'b1, 5'd5, 32'h77, 1'b0, '0, '0);
    chk("t4_replay_addr", reg_addr, 5);
    chk("t4_replay_data", reg_data, 32'h77);

    // Same-address pipe write drops the buffered entry.
    cycle(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
    cycle(1'b1, 5'd9, 32'hA, 1'b0, '0, '0);
    chk("t5_addr", reg_addr, 9);
    chk("t5_data", reg_data, 32'hA);
    chk("t5_ready", aux_ready, 1);
    idle();
    chk("t5_no_buf_write", reg_we, 0);

    // Reset while an entry is pending and a pipe write is on the port.
    cycle(1'b0, '0, '0, 1'b1, 5'd12, 32'hCC);
    cycle(1'b1, 5'd4, 32'h1, 1'b0, '0, '0);
    chk("t6_we_before", reg_we, 1);
    do_reset(1'b0);
    idle();
    chk("t6_no_old_write_a", reg_we, 0);
    idle();
    chk("t6_no_old_write_b", reg_we, 0);

    // Randomized traffic, small address range to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        cycle($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
